// File: rtl/instr_dispatcher_nslot.sv
// instr_dispatcher_nslot: routes up to NSLOT SoftMC instructions per clock onto PHY command slots.
module instr_dispatcher_nslot #(
  parameter int NSLOT = 4,
  parameter int WAIT_W = 10,
  parameter int CS_WIDTH = 1,
  parameter int WRDATA_W = 512,
  parameter logic [3:0] OPC_BUSDIR = 4'h1,
  parameter logic [3:0] OPC_WAIT = 4'h2,
  parameter logic [3:0] OPC_TREFI = 4'h3,
  parameter logic [3:0] OPC_TRFC = 4'h4,
  parameter int CKE_OFF = 27,
  parameter int CS_OFF = 22,
  parameter int RAS_OFF = 26,
  parameter int CAS_OFF = 25,
  parameter int WE_OFF = 24,
  parameter int ROW_OFF = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSLOT-1:0]      en_in,
  input  logic [32*NSLOT-1:0]   instr_in,
  output logic [NSLOT-1:0]      en_ack,
  input  logic                  periodic_read_lock,
  input  logic                  dfi_ready,
  output logic [NSLOT-1:0]      slot_dec_en,
  output logic [32*NSLOT-1:0]   slot_instr,
  output logic [NSLOT-1:0]      dfi_cke,
  output logic [NSLOT-1:0]      dfi_odt,
  output logic                  dfi_rddata_en,
  output logic                  dfi_rddata_en_pr,
  output logic                  dfi_wrdata_en,
  output logic [WRDATA_W-1:0]   dfi_wrdata,
  output logic                  io_config_strobe,
  output logic [1:0]            io_config,
  output logic                  pr_rd_ack,
  output logic                  aref_set_interval,
  output logic [27:0]           aref_interval,
  output logic                  aref_set_trfc,
  output logic [27:0]           aref_trfc
);
  localparam int PW = $clog2(NSLOT);
  logic [PW-1:0] ptr, ptr_ns, acc, q;
  logic [WAIT_W-1:0] wait_r, wait_ns, blk, w;
  logic [NSLOT-1:0] cke_r, cke_ns;
  logic [31:0] ins;
  logic [7:0] pat_r, pat_ns;
  logic [27:0] ti_ns, tf_ns;
  logic rd_any, wr_any, rd_d, pr_d, wr_d, bw_r, bw_ns, bw_ld, ti_set, tf_set;
  logic blocked, elig, act, ddr, io;
  always_comb begin
    en_ack = '0;
    slot_dec_en = '0;
    slot_instr = '0;
    cke_ns = cke_r;
    pat_ns = pat_r;
    rd_any = 1'b0;
    wr_any = 1'b0;
    io_config_strobe = 1'b0;
    io_config = 2'b00;
    bw_ld = 1'b0;
    bw_ns = bw_r;
    ti_set = 1'b0;
    tf_set = 1'b0;
    ti_ns = '0;
    tf_ns = '0;
    wait_ns = (int'(wait_r) > NSLOT) ? wait_r - WAIT_W'(NSLOT) : '0;
    acc = '0;
    blk = '0;
    w = '0;
    q = '0;
    ins = '0;
    blocked = 1'b0;
    elig = 1'b0;
    act = 1'b0;
    ddr = 1'b0;
    io = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      q = PW'((int'(ptr) + s) % NSLOT);
      ins = instr_in[32*q +: 32];
      slot_instr[32*s +: 32] = ins;
      blocked = blk != '0;
      blk = blocked ? blk - 1'b1 : blk;
      elig = dfi_ready && int'(wait_r) <= s + 1 && !blocked;
      en_ack[q] = elig;
      act = elig && en_in[q];
      ddr = act && ins[31];
      slot_dec_en[s] = ddr;
      if (ddr) cke_ns[s] = ins[CKE_OFF];
      io = ddr && ins[CS_OFF +: CS_WIDTH] == '0 && ins[RAS_OFF] && !ins[CAS_OFF] && ins[CKE_OFF] && cke_r[s];
      rd_any = rd_any | (io && ins[WE_OFF]);
      if (io && !ins[WE_OFF]) begin
        wr_any = 1'b1;
        pat_ns = {ins[30:25], ins[ROW_OFF-1 -: 2]};
      end
      if (act && ins[31:28] == OPC_WAIT) begin
        w = (ins[WAIT_W-1:0] == '0) ? WAIT_W'(1) : ins[WAIT_W-1:0];
        blk = w - 1'b1;
        wait_ns = (int'(w) > NSLOT - 1 - s) ? w - WAIT_W'(NSLOT - 1 - s) : '0;
        // (1-W) mod NSLOT, kept non-negative so the accumulation stays in range
        acc = PW'((int'(acc) + (NSLOT - (int'(w) - 1) % NSLOT) % NSLOT) % NSLOT);
      end
      if (act && ins[31:28] == OPC_BUSDIR) begin
        io_config_strobe = 1'b1;
        io_config = ins[1:0];
        bw_ld = 1'b1;
        bw_ns = ins[1:0] == 2'b01;
      end
      if (act && ins[31:28] == OPC_TREFI) begin
        ti_set = 1'b1;
        ti_ns = ins[27:0];
      end
      if (act && ins[31:28] == OPC_TRFC) begin
        tf_set = 1'b1;
        tf_ns = ins[27:0];
      end
    end
    ptr_ns = (en_in == '0) ? '0 : PW'((int'(ptr) + int'(acc)) % NSLOT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      wait_r <= '0;
      cke_r <= '1;
      rd_d <= 1'b0;
      pr_d <= 1'b0;
      wr_d <= 1'b0;
      pat_r <= '0;
      bw_r <= 1'b0;
      aref_set_interval <= 1'b0;
      aref_interval <= '0;
      aref_set_trfc <= 1'b0;
      aref_trfc <= '0;
    end else begin
      ptr <= ptr_ns;
      wait_r <= wait_ns;
      cke_r <= cke_ns;
      rd_d <= rd_any;
      pr_d <= rd_any & periodic_read_lock;
      wr_d <= wr_any;
      pat_r <= pat_ns;
      if (bw_ld) bw_r <= bw_ns;
      aref_set_interval <= ti_set;
      if (ti_set) aref_interval <= ti_ns;
      aref_set_trfc <= tf_set;
      if (tf_set) aref_trfc <= tf_ns;
    end
  end
  assign dfi_cke = cke_r;
  assign dfi_odt = {NSLOT{bw_r}};
  assign dfi_rddata_en = rd_any | rd_d;
  assign dfi_rddata_en_pr = (rd_any & periodic_read_lock) | pr_d;
  assign pr_rd_ack = rd_d;
  assign dfi_wrdata_en = wr_any | wr_d;
  assign dfi_wrdata = {(WRDATA_W/8){pat_r}};
endmodule

// File: tb/tb_instr_dispatcher_nslot.sv
// tb_instr_dispatcher_nslot: directed scoreboard bench for the 4-slot dispatcher.
module tb_instr_dispatcher_nslot;
  localparam int N = 4;
  localparam int WD = 512;
  localparam logic [31:0] NOP = 32'h8F40_0000;
  localparam logic [31:0] RD = 32'h8D00_0000;
  localparam logic [31:0] WR = 32'hDC00_000C;
  localparam logic [31:0] CKOFF = 32'h8740_0000;
  logic clk = 1'b0, rst_n = 1'b0, lock = 1'b0, ready = 1'b0;
  logic [N-1:0] en_in = '0;
  logic [32*N-1:0] instr_in = '0;
  logic [N-1:0] en_ack, slot_dec_en, dfi_cke, dfi_odt;
  logic [32*N-1:0] slot_instr;
  logic rddata_en, rddata_en_pr, wrdata_en, io_strobe, pr_rd_ack, set_int, set_trfc;
  logic [WD-1:0] wrdata;
  logic [1:0] io_config;
  logic [27:0] interval, trfc;
  instr_dispatcher_nslot dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .instr_in(instr_in), .en_ack(en_ack),
    .periodic_read_lock(lock), .dfi_ready(ready), .slot_dec_en(slot_dec_en),
    .slot_instr(slot_instr), .dfi_cke(dfi_cke), .dfi_odt(dfi_odt),
    .dfi_rddata_en(rddata_en), .dfi_rddata_en_pr(rddata_en_pr), .dfi_wrdata_en(wrdata_en),
    .dfi_wrdata(wrdata), .io_config_strobe(io_strobe), .io_config(io_config),
    .pr_rd_ack(pr_rd_ack), .aref_set_interval(set_int), .aref_interval(interval),
    .aref_set_trfc(set_trfc), .aref_trfc(trfc)
  );
  always #5 clk = ~clk;
  typedef struct {
    int kind;
    logic [WD-1:0] exp;
    string tag;
  } item_t;
  item_t sb[$];
  int n_chk = 0, n_fail = 0;
  function automatic logic [WD-1:0] obs(int k);
    case (k)
      0: return WD'(en_ack);
      1: return WD'(slot_dec_en);
      2: return WD'(rddata_en);
      3: return WD'(rddata_en_pr);
      4: return WD'(pr_rd_ack);
      5: return WD'(wrdata_en);
      6: return wrdata;
      7: return WD'(dfi_cke);
      8: return WD'(io_strobe);
      9: return WD'(io_config);
      10: return WD'(dfi_odt);
      11: return WD'(set_int);
      12: return WD'(interval);
      13: return WD'(slot_instr);
      default: return '0;
    endcase
  endfunction
  task automatic ex(input int k, input logic [WD-1:0] v, input string t);
    item_t it;
    it.kind = k;
    it.exp = v;
    it.tag = t;
    sb.push_back(it);
  endtask
  task automatic cyc();
    item_t it;
    @(negedge clk);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      n_chk++;
      assert (obs(it.kind) === it.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs(it.kind), it.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [32*N-1:0] nops();
    return {NOP | 32'd3, NOP | 32'd2, NOP | 32'd1, NOP | 32'd0};
  endfunction
  initial begin
    @(posedge clk);
    #1;
    ex(7, WD'(4'hF), "rst_cke"); ex(2, '0, "rst_rd_en"); ex(5, '0, "rst_wr_en");
    ex(6, '0, "rst_wrdata"); ex(10, '0, "rst_odt"); ex(4, '0, "rst_pr_ack");
    ex(0, '0, "rst_ack"); ex(11, '0, "rst_set_int");
    cyc();
    rst_n = 1'b1;
    ready = 1'b1;
    en_in = 4'hF;
    instr_in = nops();
    ex(0, WD'(4'hF), "nop_ack"); ex(1, WD'(4'hF), "nop_dec"); ex(13, WD'(nops()), "nop_route");
    cyc();
    ex(13, WD'(nops()), "nop_ptr0");
    cyc();
    instr_in = {NOP | 32'd3, NOP | 32'd2, 32'h2000_0006, NOP};
    ex(0, WD'(4'b0011), "w6_ack"); ex(1, WD'(4'b0001), "w6_dec");
    cyc();
    instr_in = nops();
    ex(0, WD'(4'b0100), "w6_stall_ack"); ex(1, WD'(4'b1000), "w6_stall_dec");
    ex(13, WD'({NOP | 32'd2, NOP | 32'd1, NOP | 32'd0, NOP | 32'd3}), "w6_ptr3");
    cyc();
    ex(0, WD'(4'hF), "w6_after_ack"); ex(1, WD'(4'hF), "w6_after_dec");
    ex(13, WD'({NOP | 32'd2, NOP | 32'd1, NOP | 32'd0, NOP | 32'd3}), "w6_ptr3_hold");
    cyc();
    en_in = '0;
    ex(0, WD'(4'hF), "noen_ack"); ex(1, '0, "noen_dec");
    cyc();
    en_in = 4'hF;
    instr_in = {NOP | 32'd3, 32'h2000_0001, NOP | 32'd1, 32'h2000_0001};
    ex(0, WD'(4'hF), "w1x2_ack"); ex(1, WD'(4'b1010), "w1x2_dec");
    ex(13, WD'(instr_in), "ptr_cleared");
    cyc();
    instr_in = nops();
    ex(0, WD'(4'hF), "w1x2_after_ack"); ex(13, WD'(nops()), "w1x2_ptr0");
    cyc();
    instr_in = {NOP | 32'd3, RD, NOP | 32'd1, NOP};
    lock = 1'b1;
    ex(2, WD'(1'b1), "rd_en_c0"); ex(3, WD'(1'b1), "rd_pr_c0"); ex(4, '0, "pr_ack_c0");
    ex(1, WD'(4'hF), "rd_dec");
    cyc();
    instr_in = nops();
    lock = 1'b0;
    ex(2, WD'(1'b1), "rd_en_c1"); ex(3, WD'(1'b1), "rd_pr_c1"); ex(4, WD'(1'b1), "pr_ack_c1");
    cyc();
    ex(2, '0, "rd_en_c2"); ex(3, '0, "rd_pr_c2"); ex(4, '0, "pr_ack_c2");
    cyc();
    instr_in = {NOP | 32'd3, NOP | 32'd2, WR, NOP};
    ex(5, WD'(1'b1), "wr_en_c0"); ex(6, '0, "wrdata_c0");
    cyc();
    instr_in = nops();
    ex(5, WD'(1'b1), "wr_en_c1"); ex(6, {64{8'hBB}}, "wrdata_c1");
    cyc();
    ex(5, '0, "wr_en_c2"); ex(6, {64{8'hBB}}, "wrdata_hold");
    cyc();
    instr_in = {32'h3000_0123, NOP | 32'd2, NOP | 32'd1, 32'h1000_0001};
    ex(1, WD'(4'b0110), "cfg_dec"); ex(8, WD'(1'b1), "io_strobe"); ex(9, WD'(2'b01), "io_config");
    ex(10, '0, "odt_c0"); ex(11, '0, "set_int_c0");
    cyc();
    instr_in = nops();
    ex(10, WD'(4'hF), "odt_c1"); ex(11, WD'(1'b1), "set_int_c1"); ex(12, WD'(28'h123), "interval_c1");
    ex(8, '0, "io_strobe_off");
    cyc();
    ex(11, '0, "set_int_c2"); ex(12, WD'(28'h123), "interval_hold");
    cyc();
    instr_in = {NOP | 32'd3, NOP | 32'd2, CKOFF, NOP};
    ex(1, WD'(4'hF), "ckoff_dec"); ex(7, WD'(4'hF), "cke_before");
    cyc();
    instr_in = {NOP | 32'd3, NOP | 32'd2, RD, NOP};
    ex(7, WD'(4'b1101), "cke_slot1_off"); ex(2, '0, "rd_blocked_cke");
    cyc();
    instr_in = nops();
    ex(7, WD'(4'hF), "cke_restored"); ex(2, '0, "rd_blocked_c1");
    cyc();
    ready = 1'b0;
    ex(0, '0, "notready_ack"); ex(1, '0, "notready_dec");
    cyc();
    ready = 1'b1;
    instr_in = {NOP | 32'd3, NOP | 32'd2, NOP | 32'd1, 32'h2000_0014};
    ex(0, WD'(4'b0001), "w20_ack"); ex(1, '0, "w20_dec");
    cyc();
    instr_in = nops();
    ex(0, '0, "w20_stall_ack");
    ex(13, WD'({NOP | 32'd0, NOP | 32'd3, NOP | 32'd2, NOP | 32'd1}), "w20_ptr1");
    cyc();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    ex(0, WD'(4'hF), "rst_midwait_ack"); ex(13, WD'(nops()), "rst_midwait_ptr");
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
